if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage MIPS pipeline; owns the PC and the IF/ID pipeline register that feeds ID_stage.
//  Issues req/ack fetches to instruction memory (variable latency), holds the IF/ID register while ID signals a hazard,
//  flushes on branch/jump redirect from later stages, and stops fetching when ID decodes the halt (syscall) instruction.
// PARAMETERS
//  PC_RESET  32'h0000_0000  PC value loaded on reset
//  NOP_INST  32'h0000_0000  instruction word injected as a bubble (sll $0,$0,0)
// PORTS
//  clk          in   1   pipeline clock, all state updates on posedge
//  rst          in   1   synchronous reset, active-high
//  imem_req     out  1   fetch request; held high with stable imem_addr until imem_ack
//  imem_addr    out  32  word-aligned fetch address (= pc during request)
//  imem_ack     in   1   1-cycle pulse: imem_rdata valid this cycle
//  imem_rdata   in   32  fetched instruction word
//  has_hazard   in   1   ID stall: IF/ID register must hold its contents this cycle
//  redirect     in   1   taken branch / jump / jr resolved downstream
//  redirect_pc  in   32  target PC when redirect=1
//  halted       in   1   ID is decoding the halt instruction
//  inst         out  32  IF/ID instruction to ID_stage
//  pc_plus4     out  32  IF/ID PC+4 of inst (for branch/jal targets)
//  inst_valid   out  1   IF/ID holds a real instruction (0 = bubble)
//  fetch_halted out  1   fetch stopped by halt
// BEHAVIOUR
//  Reset (rst=1 on posedge): pc=PC_RESET, state=FETCH, inst=NOP_INST, pc_plus4=0, inst_valid=0, fetch_halted=0,
//   skid empty; imem_req=0 in reset cycle. Reset mid-request abandons it (memory side tolerates a dropped req).
//  State FETCH: imem_req=1, imem_addr=pc.
//   ack & !has_hazard: IF/ID <= {imem_rdata, pc+4, valid=1}; pc<=pc+4; stay FETCH (back-to-back fetch, 1 inst/ack).
//   ack & has_hazard: IF/ID holds; word+pc+4 into skid register; go HOLD.
//   !ack & !has_hazard: IF/ID <= bubble {NOP_INST, valid=0}.  !ack & has_hazard: IF/ID holds.
//  State HOLD: imem_req=0. When has_hazard=0: IF/ID <= skid, pc<=pc+4, skid cleared, go FETCH.
//  State DRAIN: entered on redirect while a request is outstanding without ack. imem_req stays 1 with the OLD address
//   (req/addr never change before ack); returned word discarded; on ack go FETCH at the new pc.
//  State HALTED: imem_req=0, fetch_halted=1, IF/ID <= bubble; only rst exits.
//  redirect (any state except HALTED, highest priority): pc<=redirect_pc; IF/ID <= bubble (flush, ignores has_hazard);
//   skid cleared. FETCH & !ack -> DRAIN; FETCH & ack -> word discarded, FETCH; HOLD/DRAIN -> FETCH/DRAIN resp.
//  halted & !redirect & !has_hazard: go HALTED; any outstanding ack is discarded (DRAIN-like wait not required:
//   memory ack while HALTED is ignored). redirect same cycle as halted wins (halt is squashed).
//  PC arithmetic modulo 2^32: pc=32'hFFFF_FFFC +4 wraps to 0. redirect_pc[1:0] ignored (forced 00).
//  Latency: ack at cycle N -> inst visible to ID at cycle N+1. Output regs only; no comb path ack->inst.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds outputs perf_fetched[31:0] (count of words written to IF/ID with valid=1) and
//   perf_stall[31:0] (cycles with has_hazard=1 & state!=HALTED); both 0 on rst, saturate at 32'hFFFF_FFFF.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  rst 2 cycles, imem ack every cycle, words 0x20080001.. -> imem_addr 0,4,8..; inst one cycle behind, pc_plus4 4,8,..
//  ack latency 3 cycles -> imem_req/addr stable until ack; 2 bubbles (valid=0, NOP) between valid insts.
//  has_hazard=1 for 3 cycles with ack in first -> IF/ID unchanged 3 cycles, HOLD; then skid word appears, addr+4.
//  redirect to 0x100 while req pending (no ack) -> DRAIN, old word dropped, next imem_addr=0x100, IF/ID bubble.
//  halted=1 at pc=0x20 -> imem_req=0 forever, fetch_halted=1, inst_valid=0; redirect+halted same cycle -> no halt.
//  redirect_pc=32'hFFFF_FFFC, ack -> next imem_addr=0; with IF_PERF_CNT_EN: perf_fetched matches valid count.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, req/ack fetch to instruction memory, IF/ID register, skid buffer.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        has_hazard,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halted,
  output logic [31:0] inst,
  output logic [31:0] pc_plus4,
  output logic        inst_valid,
  output logic        fetch_halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_inc;
  logic [31:0] redirect_tgt;
  logic        unused_rpc_lsb;

  assign pc_inc         = pc_q + 32'd4;
  assign redirect_tgt   = {redirect_pc[31:2], 2'b00};
  assign unused_rpc_lsb = ^redirect_pc[1:0];

  // DRAIN keeps presenting the abandoned address until memory acknowledges it.
  assign imem_req     = !rst && ((state_q == S_FETCH) || (state_q == S_DRAIN));
  assign imem_addr    = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
  assign inst         = inst_q;
  assign pc_plus4     = pc4_q;
  assign inst_valid   = valid_q;
  assign fetch_halted = (state_q == S_HALTED);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    skid_inst_d  = skid_inst_q;
    skid_pc4_d   = skid_pc4_q;
    inst_d       = inst_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;

    if (state_q == S_HALTED) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (redirect) begin
      pc_d        = redirect_tgt;
      inst_d      = NOP_INST;
      valid_d     = 1'b0;
      skid_inst_d = '0;
      skid_pc4_d  = '0;
      case (state_q)
        S_FETCH: begin
          if (imem_ack) begin
            state_d = S_FETCH;
          end else begin
            state_d      = S_DRAIN;
            drain_addr_d = pc_q;
          end
        end
        S_HOLD:  state_d = S_FETCH;
        S_DRAIN: state_d = imem_ack ? S_FETCH : S_DRAIN;
        default: state_d = state_q;
      endcase
    end else if (halted && !has_hazard) begin
      state_d     = S_HALTED;
      inst_d      = NOP_INST;
      valid_d     = 1'b0;
      skid_inst_d = '0;
      skid_pc4_d  = '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ack) begin
            if (!has_hazard) begin
              inst_d  = imem_rdata;
              pc4_d   = pc_inc;
              valid_d = 1'b1;
              pc_d    = pc_inc;
            end else begin
              skid_inst_d = imem_rdata;
              skid_pc4_d  = pc_inc;
              state_d     = S_HOLD;
            end
          end else if (!has_hazard) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!has_hazard) begin
            inst_d      = skid_inst_q;
            pc4_d       = skid_pc4_q;
            valid_d     = 1'b1;
            pc_d        = pc_inc;
            skid_inst_d = '0;
            skid_pc4_d  = '0;
            state_d     = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (!has_hazard) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
          end
          if (imem_ack) begin
            state_d = S_FETCH;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= PC_RESET;
      drain_addr_q <= PC_RESET;
      skid_inst_q  <= '0;
      skid_pc4_q   <= '0;
      inst_q       <= NOP_INST;
      pc4_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc4_q   <= skid_pc4_d;
      inst_q       <= inst_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetched_q;
  logic [31:0] stall_q;
  logic        fetch_load;

  // A real instruction enters IF/ID only from a fresh ack or a skid release, with no flush/halt/stall.
  assign fetch_load = (((state_q == S_FETCH) && imem_ack) || (state_q == S_HOLD))
                      && !has_hazard && !redirect && !halted;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      if (fetch_load && (fetched_q != '1)) begin
        fetched_q <= fetched_q + 32'd1;
      end
      if (has_hazard && (state_q != S_HALTED) && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic against a
// transaction-level reference model of the fetch stage and a variable-latency memory.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0, imem_ack = 1'b0, has_hazard = 1'b0, redirect = 1'b0, halted = 1'b0;
  logic        imem_req, inst_valid, fetch_halted;
  logic [31:0] imem_addr, inst, pc_plus4;
  logic [31:0] imem_rdata = '0, redirect_pc = '0;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  if_stage #(.PC_RESET(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .has_hazard(has_hazard), .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted),
    .inst(inst), .pc_plus4(pc_plus4), .inst_valid(inst_valid), .fetch_halted(fetch_halted)
`ifdef IF_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  // reference model: fetch pointer, one-deep pending word, abandoned-request flag, halt flag, IF/ID contents
  logic [31:0] m_pc, m_inst, m_pc4, m_skid_word, m_skid_pc4, m_drain_addr;
  logic [31:0] m_fetched, m_stall;
  bit          m_valid, m_halt, m_has_skid, m_draining;
  bit          exp_req, obs_req;
  logic [31:0] exp_addr, obs_addr;
  int unsigned mem_lat = 1, wcnt = 0;
  bit          rand_lat = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h2008_0001 + (a >> 2);
  endfunction

  task automatic drive_cycle(input bit r, input bit hz, input bit rd, input logic [31:0] rpc, input bit hl);
    bit acked;
    logic [31:0] w;
    @(negedge clk);
    rst = r; has_hazard = hz; redirect = rd; redirect_pc = rpc; halted = hl;
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    #1;
    exp_req  = !r && !m_halt && !m_has_skid;
    exp_addr = m_draining ? m_drain_addr : m_pc;
    obs_req  = imem_req;
    obs_addr = imem_addr;
    if (imem_req === 1'b1) begin
      if (wcnt + 1 >= mem_lat) begin
        imem_ack = 1'b1; imem_rdata = word_at(imem_addr); wcnt = 0;
        if (rand_lat) mem_lat = $urandom_range(1, 4);
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
    acked = imem_ack && exp_req;
    w = word_at(exp_addr);
    @(posedge clk);
    if (r) begin
      m_pc = '0; m_inst = NOP; m_pc4 = '0; m_valid = 0; m_halt = 0; m_has_skid = 0;
      m_draining = 0; m_fetched = '0; m_stall = '0;
    end else begin
      if (hz && !m_halt && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (m_halt) begin
        m_inst = NOP; m_valid = 0;
      end else if (rd) begin
        m_draining = exp_req && !acked;
        m_drain_addr = exp_addr;
        m_pc = {rpc[31:2], 2'b00}; m_inst = NOP; m_valid = 0; m_has_skid = 0;
      end else if (hl && !hz) begin
        m_halt = 1; m_inst = NOP; m_valid = 0; m_has_skid = 0; m_draining = 0;
      end else if (m_has_skid) begin
        if (!hz) begin
          m_inst = m_skid_word; m_pc4 = m_skid_pc4; m_valid = 1; m_pc = m_pc + 4; m_has_skid = 0;
          if (m_fetched != 32'hFFFF_FFFF) m_fetched++;
        end
      end else if (acked && !m_draining) begin
        if (!hz) begin
          m_inst = w; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
          if (m_fetched != 32'hFFFF_FFFF) m_fetched++;
        end else begin
          m_has_skid = 1; m_skid_word = w; m_skid_pc4 = m_pc + 4;
        end
      end else begin
        if (acked) m_draining = 0;
        if (!hz) begin m_inst = NOP; m_valid = 0; end
      end
    end
    #1;
  endtask

  task automatic apply_reset;
    drive_cycle(1, 0, 0, '0, 0);
    drive_cycle(1, 0, 0, '0, 0);
  endtask

  task automatic test_reset;
    mem_lat = 1; rand_lat = 0;
    drive_cycle(1, 0, 0, '0, 0);
    n_tests++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", obs_req); end
    drive_cycle(1, 0, 0, '0, 0);
    n_tests++; if (inst !== NOP) begin n_fail++; $display("FAIL reset_inst got %h exp %h", inst, NOP); end
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
    n_tests++; if (pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4 got %h exp 0", pc_plus4); end
    n_tests++; if (fetch_halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b exp 0", fetch_halted); end
    drive_cycle(0, 0, 0, '0, 0);
    n_tests++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin n_fail++; $display("FAIL reset_first_fetch got req=%b addr=%h exp req=1 addr=0", obs_req, obs_addr); end
    mem_lat = 3;
    drive_cycle(0, 0, 0, '0, 0);
    drive_cycle(1, 0, 0, '0, 0);
    n_tests++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL reset_midreq_req got %b exp 0", obs_req); end
    drive_cycle(0, 0, 0, '0, 0);
    n_tests++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin n_fail++; $display("FAIL reset_midreq_restart got req=%b addr=%h exp req=1 addr=0", obs_req, obs_addr); end
  endtask

  task automatic test_stream;
    logic [31:0] ea, ei;
    mem_lat = 1; rand_lat = 0;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      drive_cycle(0, 0, 0, '0, 0);
      ea = 32'(4 * k); ei = 32'h2008_0001 + 32'(k);
      n_tests++; if (obs_req !== 1'b1 || obs_addr !== ea) begin n_fail++; $display("FAIL stream_addr k=%0d got req=%b addr=%h exp req=1 addr=%h", k, obs_req, obs_addr, ea); end
      n_tests++; if (inst !== ei || inst_valid !== 1'b1 || pc_plus4 !== ea + 4) begin n_fail++; $display("FAIL stream_ifid k=%0d got %h/%h/%b exp %h/%h/1", k, inst, pc_plus4, inst_valid, ei, ea + 4); end
    end
  endtask

  task automatic test_latency;
    logic [31:0] ea, ei;
    bit ev;
    mem_lat = 3; rand_lat = 0;
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      drive_cycle(0, 0, 0, '0, 0);
      ea = 32'(4 * (k / 3)); ev = (k % 3 == 2); ei = ev ? 32'h2008_0001 + 32'(k / 3) : NOP;
      n_tests++; if (obs_req !== 1'b1 || obs_addr !== ea) begin n_fail++; $display("FAIL latency_addr k=%0d got req=%b addr=%h exp req=1 addr=%h", k, obs_req, obs_addr, ea); end
      n_tests++; if (inst_valid !== ev || inst !== ei) begin n_fail++; $display("FAIL latency_ifid k=%0d got %h/%b exp %h/%b", k, inst, inst_valid, ei, ev); end
    end
  endtask

  task automatic test_hazard;
    mem_lat = 1; rand_lat = 0;
    apply_reset();
    drive_cycle(0, 0, 0, '0, 0);
    drive_cycle(0, 0, 0, '0, 0);
    for (int k = 0; k < 3; k++) begin
      drive_cycle(0, 1, 0, '0, 0);
      n_tests++; if (obs_req !== (k == 0) || (k == 0 && obs_addr !== 32'h8)) begin n_fail++; $display("FAIL hazard_req k=%0d got req=%b addr=%h exp req=%b addr=8", k, obs_req, obs_addr, k == 0); end
      n_tests++; if (inst !== 32'h2008_0002 || pc_plus4 !== 32'h8 || inst_valid !== 1'b1) begin n_fail++; $display("FAIL hazard_hold k=%0d got %h/%h/%b exp 20080002/00000008/1", k, inst, pc_plus4, inst_valid); end
    end
    drive_cycle(0, 0, 0, '0, 0);
    n_tests++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL hazard_release_req got %b exp 0", obs_req); end
    n_tests++; if (inst !== 32'h2008_0003 || pc_plus4 !== 32'hC || inst_valid !== 1'b1) begin n_fail++; $display("FAIL hazard_skid got %h/%h/%b exp 20080003/0000000c/1", inst, pc_plus4, inst_valid); end
    drive_cycle(0, 0, 0, '0, 0);
    n_tests++; if (obs_req !== 1'b1 || obs_addr !== 32'hC) begin n_fail++; $display("FAIL hazard_resume got req=%b addr=%h exp req=1 addr=c", obs_req, obs_addr); end
  endtask

  task automatic test_redirect_drain;
    mem_lat = 3; rand_lat = 0;
    apply_reset();
    drive_cycle(0, 0, 0, '0, 0);
    drive_cycle(0, 0, 1, 32'h100, 0);
    n_tests++; if (inst_valid !== 1'b0 || inst !== NOP) begin n_fail++; $display("FAIL drain_flush got %h/%b exp %h/0", inst, inst_valid, NOP); end
    drive_cycle(0, 0, 0, '0, 0);
    n_tests++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin n_fail++; $display("FAIL drain_old_addr got req=%b addr=%h exp req=1 addr=0", obs_req, obs_addr); end
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL drain_discard got valid=%b exp 0", inst_valid); end
    drive_cycle(0, 0, 0, '0, 0);
    n_tests++; if (obs_req !== 1'b1 || obs_addr !== 32'h100) begin n_fail++; $display("FAIL drain_new_addr got req=%b addr=%h exp req=1 addr=100", obs_req, obs_addr); end
    drive_cycle(0, 0, 0, '0, 0);
    drive_cycle(0, 0, 0, '0, 0);
    n_tests++; if (inst !== 32'h2008_0041 || pc_plus4 !== 32'h104 || inst_valid !== 1'b1) begin n_fail++; $display("FAIL drain_target got %h/%h/%b exp 20080041/00000104/1", inst, pc_plus4, inst_valid); end
  endtask

  task automatic test_halt;
    mem_lat = 1; rand_lat = 0;
    apply_reset();
    for (int k = 0; k < 8; k++) drive_cycle(0, 0, 0, '0, 0);
    drive_cycle(0, 0, 0, '0, 1);
    n_tests++; if (obs_addr !== 32'h20) begin n_fail++; $display("FAIL halt_at_addr got %h exp 20", obs_addr); end
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (fetch_halted !== 1'b1 || inst_valid !== 1'b0 || inst !== NOP) begin n_fail++; $display("FAIL halt_state k=%0d got fh=%b valid=%b inst=%h exp fh=1 valid=0 inst=%h", k, fetch_halted, inst_valid, inst, NOP); end
      drive_cycle(0, k == 2, k == 3, 32'h200, 0);
      n_tests++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL halt_req k=%0d got %b exp 0", k, obs_req); end
    end
`ifdef IF_PERF_CNT_EN
    n_tests++; if (perf_fetched !== 32'd8) begin n_fail++; $display("FAIL halt_perf_fetched got %0d exp 8", perf_fetched); end
    n_tests++; if (perf_stall !== 32'd0) begin n_fail++; $display("FAIL halt_perf_stall got %0d exp 0", perf_stall); end
`endif
    apply_reset();
    drive_cycle(0, 0, 0, '0, 0);
    drive_cycle(0, 0, 0, '0, 0);
    drive_cycle(0, 0, 1, 32'h40, 1);
    n_tests++; if (fetch_halted !== 1'b0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL halt_squash got fh=%b valid=%b exp fh=0 valid=0", fetch_halted, inst_valid); end
    drive_cycle(0, 0, 0, '0, 0);
    n_tests++; if (obs_req !== 1'b1 || obs_addr !== 32'h40) begin n_fail++; $display("FAIL halt_squash_fetch got req=%b addr=%h exp req=1 addr=40", obs_req, obs_addr); end
  endtask

  task automatic test_wrap;
    mem_lat = 1; rand_lat = 0;
    apply_reset();
    drive_cycle(0, 0, 1, 32'hFFFF_FFFF, 0);
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_discard got valid=%b exp 0", inst_valid); end
    drive_cycle(0, 0, 0, '0, 0);
    n_tests++; if (obs_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_target got %h exp fffffffc", obs_addr); end
    n_tests++; if (inst !== 32'h6008_0000 || pc_plus4 !== 32'h0 || inst_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_ifid got %h/%h/%b exp 60080000/00000000/1", inst, pc_plus4, inst_valid); end
    drive_cycle(0, 0, 0, '0, 0);
    n_tests++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next got req=%b addr=%h exp req=1 addr=0", obs_req, obs_addr); end
  endtask

  task automatic test_random;
    bit r, hz, rd, hl;
    logic [31:0] rpc;
    rand_lat = 1; mem_lat = 2;
    apply_reset();
    for (int k = 0; k < 3000; k++) begin
      r   = ($urandom_range(0, 99) == 0);
      hz  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 11) == 0);
      hl  = ($urandom_range(0, 49) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom();
      drive_cycle(r, hz, rd, rpc, hl);
      n_tests++; if (obs_req !== exp_req) begin n_fail++; $display("FAIL rand_req k=%0d got %b exp %b", k, obs_req, exp_req); end
      if (exp_req) begin
        n_tests++; if (obs_addr !== exp_addr) begin n_fail++; $display("FAIL rand_addr k=%0d got %h exp %h", k, obs_addr, exp_addr); end
      end
      n_tests++; if (inst !== m_inst || inst_valid !== m_valid) begin n_fail++; $display("FAIL rand_ifid k=%0d got %h/%b exp %h/%b", k, inst, inst_valid, m_inst, m_valid); end
      if (m_valid) begin
        n_tests++; if (pc_plus4 !== m_pc4) begin n_fail++; $display("FAIL rand_pc4 k=%0d got %h exp %h", k, pc_plus4, m_pc4); end
      end
      n_tests++; if (fetch_halted !== m_halt) begin n_fail++; $display("FAIL rand_halted k=%0d got %b exp %b", k, fetch_halted, m_halt); end
`ifdef IF_PERF_CNT_EN
      n_tests++; if (perf_fetched !== m_fetched || perf_stall !== m_stall) begin n_fail++; $display("FAIL rand_perf k=%0d got %0d/%0d exp %0d/%0d", k, perf_fetched, perf_stall, m_fetched, m_stall); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_latency();
    test_hazard();
    test_redirect_drain();
    test_halt();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
